serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 167 ++++++++++++++++
 tb/tb_serial_adder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one fulladder slice fed LSB-first from shift registers.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_ADDER_OVF_EN.

module fulladder (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);
    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));
endmodule

// state  | meaning
// IDLE   | waiting for start; S/Co hold the last result
// SHIFT  | one operand bit pair per cycle through the slice
// DONE   | publish sum register and carry, pulse done
module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Co
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  s_q, s_d;
    logic          co_q, co_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic          cmsb_q, cmsb_d;
    logic          ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_co;

    fulladder u_fa (
        .A  (a_q[0]),
        .B  (b_q[0]),
        .Ci (carry_q),
        .S  (fa_s),
        .Co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        s_d     = s_q;
        co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
        cmsb_d  = cmsb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Ci;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sum_d   = {fa_s, sum_q[N-1:1]};
                carry_d = fa_co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB slice
                    cmsb_d  = carry_q;
`endif
                end
            end
            ST_DONE: begin
                s_d     = sum_q;
                co_d    = carry_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
`ifdef SERIAL_ADDER_OVF_EN
                ovf_d   = cmsb_q ^ carry_q;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
            co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q  <= cmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=8): vector table, corner sequences, random ops vs. arithmetic model.
module tb_serial_adder;
    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         ci_i;
    logic         busy;
    logic         done;
    logic [N-1:0] s_o;
    logic         co_o;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_i),
        .B     (b_i),
        .Ci    (ci_i),
        .busy  (busy),
        .done  (done),
        .S     (s_o),
        .Co    (co_o)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         ci;
        logic [N-1:0] exp_s;
        logic         exp_co;
        logic         exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation: start for one edge, scramble inputs afterwards, measure latency and busy span.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                          input logic [N-1:0] es, input logic eco, input logic eovf,
                          input string tag);
        int lat;
        int busy_cnt;
        a_i = a; b_i = b; ci_i = ci; start = 1'b1;
        tick();
        start = 1'b0;
        a_i = ~a; b_i = N'($urandom); ci_i = ~ci;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 4 * N) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, N + 1);
        check({tag, " busy cycles"}, busy_cnt, N + 1);
        check({tag, " S"}, 32'(s_o), 32'(es));
        check({tag, " Co"}, 32'(co_o), 32'(eco));
        check({tag, " busy at done"}, 32'(busy), 0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, " ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) $display("unexpected x in ovf expectation");
`endif
        tick();
        check({tag, " done one cycle"}, 32'(done), 0);
        check({tag, " S held"}, 32'(s_o), 32'(es));
    endtask

    function automatic logic [N:0] model_sum(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
        return (N + 1)'(a) + (N + 1)'(b) + (N + 1)'(ci);
    endfunction

    function automatic logic model_ovf(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
        int sa, sb, sum;
        sa  = a[N-1] ? int'(a) - (1 << N) : int'(a);
        sb  = b[N-1] ? int'(b) - (1 << N) : int'(b);
        sum = sa + sb + int'(ci);
        return (sum > (1 << (N - 1)) - 1) || (sum < -(1 << (N - 1)));
    endfunction

    vec_t vecs[7];

    initial begin
        int lat;
        int pulses;
        int last;
        int saw_done;
        logic [N-1:0] ra, rb;
        logic rc;
        logic [N:0] rs;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0; ci_i = 1'b0;
        tick(); tick();
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset S", 32'(s_o), 0);
        check("reset Co", 32'(co_o), 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset ovf", 32'(ovf), 0);
`endif
        start = 1'b1; a_i = 8'h11; b_i = 8'h22;
        tick();
        check("rst beats start", 32'(busy), 0);
        rst = 1'b0; start = 1'b0;
        tick();

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].exp_s, vecs[i].exp_co,
                   vecs[i].exp_ovf, $sformatf("vec%0d", i));

        // start re-pulsed mid-SHIFT must not disturb the running operation
        a_i = 8'h12; b_i = 8'h34; ci_i = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 4 * N) begin
            start = (lat == 3);
            a_i = 8'hAA; b_i = 8'h55; ci_i = 1'b1;
            tick();
            lat++;
        end
        start = 1'b0;
        check("ignored start latency", lat, N + 1);
        check("ignored start S", 32'(s_o), 32'h46);
        check("ignored start Co", 32'(co_o), 0);
        tick(); tick();
        check("ignored start not queued", 32'(busy), 0);

        // reset during the 4th SHIFT cycle
        a_i = 8'hC3; b_i = 8'h5D; ci_i = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(busy), 0);
        check("abort S", 32'(s_o), 0);
        check("abort Co", 32'(co_o), 0);
        check("abort done", 32'(done), 0);
        saw_done = 0;
        for (int i = 0; i < N + 4; i++) begin
            if (done) saw_done = 1;
            tick();
        end
        check("abort no done pulse", saw_done, 0);
        run_op(8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1, 1'b0, "after abort");

        // start held high: back-to-back ops every N+2 cycles
        a_i = 8'h01; b_i = 8'h02; ci_i = 1'b0; start = 1'b1;
        pulses = 0;
        last = -1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (done) begin
                pulses++;
                check("held S", 32'(s_o), 32'h03);
                if (last < 0) check("held first done", t, N + 2);
                else check("held period", t - last, N + 2);
                last = t;
            end
        end
        start = 1'b0;
        check("held pulse count", pulses, 3);
        for (int i = 0; i < 2 * N; i++) tick();

        // random operations against the arithmetic model
        for (int i = 0; i < 25; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            rs = model_sum(ra, rb, rc);
            run_op(ra, rb, rc, rs[N-1:0], rs[N], model_ovf(ra, rb, rc), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
